// File: rtl/cpu_mem_responder.sv
// Load/store responder for the multi-cycle core: word RAM with byte/half lanes plus EOP and cycle-counter MMIO.
// Response LATENCY+1 cycles after acceptance; REQ is ignored while BUSY, so the core holds off until ACK.
module cpu_mem_responder #(
   parameter int          MEM_WORDS = 1024,
   parameter int          LATENCY   = 2,
   parameter logic [31:0] EOP_ADDR  = 32'hFFFF_FFF0,
   parameter logic [31:0] CYC_ADDR  = 32'hFFFF_FFF4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        REQ,
   input  logic        WE,
   input  logic [31:0] ADDR,
   input  logic [1:0]  SIZE,
   input  logic        UNSIGNED,
   input  logic [31:0] WDATA,
   output logic [31:0] RDATA,
   output logic        ACK,
   output logic        ERR,
   output logic        BUSY,
   output logic        EOP
);

   localparam int          AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam logic [32:0] RAM_BYTES = 33'(4 * MEM_WORDS);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state, state_n;
   logic [3:0]  cnt, cnt_n;
   logic        a_we, a_uns;
   logic [1:0]  a_size;
   logic [31:0] a_addr, a_wdata;
   logic [31:0] cycles;
   logic [31:0] mem [MEM_WORDS];

   logic        misalign, fault, hit_eop, hit_cyc, hit_ram;
   logic [AW-1:0] idx;
   logic [31:0] mem_word, load_val, wdata_rep;
   logic [15:0] lane;
   logic [3:0]  be;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
         IDLE: if (REQ) begin
            if (LATENCY == 0) begin
               state_n = RESP;
            end else begin
               state_n = WAIT;
               cnt_n   = 4'(LATENCY - 1);
            end
         end
         WAIT: begin
            if (cnt == 4'd0) state_n = RESP;
            else             cnt_n   = cnt - 4'd1;
         end
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         a_we    <= 1'b0;
         a_uns   <= 1'b0;
         a_size  <= 2'b00;
         a_addr  <= '0;
         a_wdata <= '0;
      end else if (state == IDLE && REQ) begin
         a_we    <= WE;
         a_uns   <= UNSIGNED;
         a_size  <= SIZE;
         a_addr  <= ADDR;
         a_wdata <= WDATA;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) cycles <= '0;
      else      cycles <= cycles + 32'd1;
   end

   // Fault checks take priority over every address match, MMIO included.
   assign misalign = (a_size == 2'b01 && a_addr[0]) ||
                     (a_size == 2'b10 && a_addr[1:0] != 2'b00);

   always_comb begin
      fault   = 1'b0;
      hit_eop = 1'b0;
      hit_cyc = 1'b0;
      hit_ram = 1'b0;
      if (a_size == 2'b11 || misalign)
         fault = 1'b1;
      else if (a_addr == EOP_ADDR && a_size == 2'b10)
         hit_eop = 1'b1;
      else if (a_addr == CYC_ADDR && a_size == 2'b10)
         hit_cyc = 1'b1;
      else if ({1'b0, a_addr} < RAM_BYTES && a_addr != EOP_ADDR && a_addr != CYC_ADDR)
         hit_ram = 1'b1;
      else
         fault = 1'b1;
   end

   assign idx      = a_addr[AW+1:2];
   assign mem_word = mem[idx];
   assign lane     = 16'(mem_word >> {a_addr[1:0], 3'b000});

   always_comb begin
      load_val  = mem_word;
      wdata_rep = a_wdata;
      be        = 4'b1111;
      case (a_size)
         2'b00: begin
            load_val  = a_uns ? {24'b0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
            wdata_rep = {4{a_wdata[7:0]}};
            be        = 4'b0001 << a_addr[1:0];
         end
         2'b01: begin
            load_val  = a_uns ? {16'b0, lane} : {{16{lane[15]}}, lane};
            wdata_rep = {2{a_wdata[15:0]}};
            be        = a_addr[1] ? 4'b1100 : 4'b0011;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST && state == RESP && hit_ram && a_we) begin
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST)
         EOP <= 1'b0;
      else if (state == RESP && hit_eop && a_we && a_wdata[0])
         EOP <= 1'b1;
   end

   assign ACK  = (state == RESP);
   assign ERR  = ACK && fault;
   assign BUSY = (state != IDLE);

   always_comb begin
      RDATA = '0;
      if (ACK && !a_we) begin
         if (hit_eop)      RDATA = {31'b0, EOP};
         else if (hit_cyc) RDATA = cycles;
         else if (hit_ram) RDATA = load_val;
      end
   end

endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Memory-side responder for the multi-cycle RISC-V core: services load/store requests over a REQ/ACK handshake with a parameterised wait latency.
- Backs a word-addressed data RAM with byte/half/word lanes and load sign extension.
- Exposes two MMIO registers: an end-of-program flag driving EOP, and a free-running cycle counter, so benches can stop simulation and report cycle counts.

Parameters:
MEM_WORDS, 1024, number of 32-bit RAM words; valid RAM bytes are 0 .. 4*MEM_WORDS-1.
LATENCY, 2, wait cycles between request acceptance and response; legal range 0..15.
EOP_ADDR, 32'hFFFF_FFF0, MMIO address of the end-of-program register.
CYC_ADDR, 32'hFFFF_FFF4, MMIO address of the read-only cycle counter.

Ports:
CLK  input  1  system clock, all logic on rising edge.
RST  input  1  synchronous, active-low reset.
REQ  input  1  request strobe; sampled only in IDLE.
WE  input  1  1 = store, 0 = load.
ADDR  input  32  byte address.
SIZE  input  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
UNSIGNED  input  1  load zero-extends when 1 and sign-extends when 0; ignored for stores and word loads.
WDATA  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
RDATA  output  32  load result; valid only in the ACK cycle and 0 otherwise.
ACK  output  1  one-cycle response pulse.
ERR  output  1  asserted together with ACK when the access faults.
BUSY  output  1  high from the cycle after acceptance through the ACK cycle.
EOP  output  1  sticky end-of-program flag.

Behaviour:
- Reset (RST=0 at a clock edge):
  - ACK, ERR, BUSY and EOP are 0; RDATA is 0; the FSM returns to IDLE; the cycle counter is 0.
  - Any in-flight access is aborted with no write and no ACK.
  - RAM contents are not cleared.
- Cycle counter: 32-bit, increments every non-reset cycle, wraps from FFFF_FFFF to 0.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: when REQ=1, capture ADDR, WE, SIZE, UNSIGNED and WDATA. Go to WAIT with wait count = LATENCY-1, or go directly to RESP if LATENCY=0.
  - WAIT: decrement the count each cycle; when the count reaches 0, go to RESP next cycle.
  - RESP: perform the access, drive ACK=1 for exactly one cycle, then return to IDLE.
  - REQ is ignored in WAIT and RESP; the core must hold off until ACK.
- Timing: request accepted at edge N gives ACK high during cycle N+LATENCY+1. Back-to-back requests are allowed: REQ may be high in the cycle after ACK.
- Decode of the captured request, in priority order:
  - SIZE=11, or misaligned access (half with ADDR[0]=1; word with ADDR[1:0]≠00): ERR=1, no write, RDATA=0.
  - ADDR==EOP_ADDR with SIZE=10:
    - Store with WDATA[0]=1 sets EOP; a store with WDATA[0]=0 has no effect. EOP is cleared only by reset.
    - Load returns {31'b0, EOP}.
  - ADDR==CYC_ADDR with SIZE=10:
    - Load returns the counter value in the RESP cycle.
    - Store is ACKed with no ERR and no effect.
  - ADDR within RAM: little-endian lane access.
    - Store writes only the addressed bytes.
    - Load extracts the addressed lane and extends it per UNSIGNED.
  - Anything else (out-of-range address, or MMIO address with SIZE≠10): ERR=1, no write, RDATA=0.
- EOP rises in the cycle after the ACK edge of the setting store. Requests continue to be serviced after EOP is set.
- ERR is 0 whenever ACK is 0.

Test Plan:
- Reset hold, then release; store word 0xDEADBEEF to 0x10; load word 0x10 with LATENCY=2 -> ACK exactly 3 cycles after REQ acceptance, RDATA=0xDEADBEEF, ERR=0, BUSY high for 3 cycles.
- Store byte 0x80 to 0x11, then load byte at 0x11 with UNSIGNED=0 -> RDATA=0xFFFFFF80; same load with UNSIGNED=1 -> 0x00000080; load word 0x10 -> 0xDEAD80EF.
- Load half at 0x13 and load word at 0x12 -> each ACK with ERR=1, RDATA=0; a subsequent word load at 0x10 confirms memory unchanged.
- Store word 0x1 to EOP_ADDR -> EOP=1 the cycle after ACK and remains 1 through further requests; load EOP_ADDR -> RDATA=1; RST=0 -> EOP=0.
- Two loads of CYC_ADDR issued back-to-back with LATENCY=0 -> RDATA values differ by exactly 2; store to CYC_ADDR -> ACK, ERR=0, counter unaffected.
- Issue a store, assert RST=0 during WAIT -> no ACK, target word unchanged on a later read; REQ pulsed during WAIT -> ignored, exactly one ACK per accepted request.
